// File: rtl/pp_buf_rd_stream_pkg.sv
// ---------------------------------------------------------------------------
// ping_pong_pkg
// Definitions shared by the ping-pong buffer reader and writer controllers:
// the bank FSM state encoding, the bank index width and the bank count.
// ---------------------------------------------------------------------------
package ping_pong_pkg;

  localparam int BANK_W    = 1;
  localparam int NUM_BANKS = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } pp_state_e;

  // One-hot mask selecting a single bank inside a per-bank flag vector.
  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_W-1:0] bank);
    logic [NUM_BANKS-1:0] one;
    one = {{(NUM_BANKS-1){1'b0}}, 1'b1};
    return one << bank;
  endfunction

endpackage

// File: rtl/pp_buf_rd_stream_if.sv
// ---------------------------------------------------------------------------
// pp_buf_rd_stream_if
// AXI4-Stream bundle carried out of the ping-pong buffer reader.
//   tdata  : stream word
//   tvalid : word valid
//   tready : sink ready
//   tlast  : final word of a bank
// master drives tdata/tvalid/tlast, slave drives tready.
// ---------------------------------------------------------------------------
interface pp_buf_rd_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pp_buf_rd_stream_skid_fifo.sv
// ---------------------------------------------------------------------------
// pp_skid_fifo
// Two-entry FIFO holding RAM read data in front of the stream output.
//   clk, resetn : clock, asynchronous active-low reset
//   push, din   : write one entry (caller guarantees it is not full)
//   pop         : drop the head entry (ignored when empty)
//   dout        : head entry, stable until popped
//   count       : occupancy 0..2
// Push and pop in the same cycle are both honoured.
// ---------------------------------------------------------------------------
module pp_skid_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             pop_ok;

  assign pop_ok = pop && (count_reg != 2'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= din;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop_ok) rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop_ok})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/pp_buf_rd_stream.sv
// ---------------------------------------------------------------------------
// pp_buf_rd_stream
// Read side of the ping-pong buffer. Waits for the writer to mark a bank full,
// reads it out of dp_ram port B in strict bank order 0,1,0,..., streams the
// words as AXI4-Stream and hands the bank back to the writer.
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   wr_done_i, wr_bank_i         writer finished filling a bank (pulse + index)
//   rd_release_o, rd_rel_bank_o  bank fully streamed (pulse + index)
//   bank_full_o                  per-bank full flags
//   ram_enb_o, ram_addrb_o       dp_ram port B enable and {bank, word} address
//   ram_dob_i                    dp_ram read data, one cycle after enable
//   m_axis                       AXI4-Stream master
//   err_o                        sticky: writer reported a bank that was still full
// ---------------------------------------------------------------------------
module pp_buf_rd_stream
  import ping_pong_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDRW      = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_done_i,
  input  logic [BANK_W-1:0]       wr_bank_i,
  output logic                    rd_release_o,
  output logic [BANK_W-1:0]       rd_rel_bank_o,
  output logic [NUM_BANKS-1:0]    bank_full_o,
  output logic                    ram_enb_o,
  output logic [ADDRW:0]          ram_addrb_o,
  input  logic [DATA_WIDTH-1:0]   ram_dob_i,
  pp_buf_rd_stream_if.master      m_axis,
  output logic                    err_o
);

  localparam logic [ADDRW-1:0] LAST_IDX = ADDRW'(DEPTH - 1);

  pp_state_e             state_reg;
  logic [BANK_W-1:0]     cur_bank_reg;
  logic [ADDRW-1:0]      idx_reg;
  logic [NUM_BANKS-1:0]  full_reg;
  logic [NUM_BANKS-1:0]  full_next;
  logic                  err_reg;
  logic                  inflight_reg;       // read issued last cycle, data on ram_dob_i now
  logic                  inflight_last_reg;  // ...and it was word DEPTH-1
  logic                  release_reg;
  logic [BANK_W-1:0]     rel_bank_reg;

  logic [DATA_WIDTH:0]   fifo_din;
  logic [DATA_WIDTH:0]   fifo_dout;
  logic [1:0]            fifo_count;
  logic                  fifo_valid;
  logic                  fifo_pop;
  logic [1:0]            credit;
  logic                  rd_issue;
  logic                  last_issue;
  logic                  drain_done;
  logic                  err_set;

  always_comb begin
    fifo_valid = (fifo_count != 2'd0);
    fifo_pop   = fifo_valid && m_axis.tready;
    // A head word leaving this cycle frees its slot in time for a read issued
    // now, which keeps a full-rate stream when the sink never stalls. Reads in
    // the FIFO plus the one in flight never exceed two, so this stays in 0..2.
    credit     = 2'd2 + {1'b0, fifo_pop} - fifo_count - {1'b0, inflight_reg};
    rd_issue   = (state_reg == ST_STREAM) && (credit != 2'd0);
    last_issue = rd_issue && (idx_reg == LAST_IDX);
    // The last word can only be in the FIFO once the FSM has reached DRAIN.
    drain_done = (state_reg == ST_DRAIN) && fifo_pop && fifo_dout[DATA_WIDTH];
    err_set    = wr_done_i && full_reg[wr_bank_i];
    // Clear first, then set, so a same-bank collision leaves the flag set.
    full_next  = full_reg;
    if (drain_done) full_next = full_next & ~bank_onehot(cur_bank_reg);
    if (wr_done_i)  full_next = full_next | bank_onehot(wr_bank_i);
    fifo_din   = {inflight_last_reg, ram_dob_i};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg         <= ST_IDLE;
      cur_bank_reg      <= '0;
      idx_reg           <= '0;
      full_reg          <= '0;
      err_reg           <= 1'b0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      release_reg       <= 1'b0;
      rel_bank_reg      <= '0;
    end else begin
      full_reg          <= full_next;
      inflight_reg      <= rd_issue;
      inflight_last_reg <= last_issue;
      release_reg       <= drain_done;
      if (err_set)    err_reg      <= 1'b1;
      if (drain_done) rel_bank_reg <= cur_bank_reg;

      case (state_reg)
        ST_IDLE: begin
          if (full_reg[cur_bank_reg]) begin
            idx_reg   <= '0;
            state_reg <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (rd_issue) begin
            // idx holds at DEPTH-1 rather than wrapping into the next frame.
            if (idx_reg == LAST_IDX) state_reg <= ST_DRAIN;
            else                     idx_reg   <= idx_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            cur_bank_reg <= ~cur_bank_reg;
            state_reg    <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  pp_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (inflight_reg),
    .pop    (fifo_pop),
    .din    (fifo_din),
    .dout   (fifo_dout),
    .count  (fifo_count)
  );

  assign ram_enb_o     = rd_issue;
  assign ram_addrb_o   = {cur_bank_reg, idx_reg};
  assign bank_full_o   = full_reg;
  assign err_o         = err_reg;
  assign rd_release_o  = release_reg;
  assign rd_rel_bank_o = rel_bank_reg;
  assign m_axis.tdata  = fifo_dout[DATA_WIDTH-1:0];
  assign m_axis.tvalid = fifo_valid;
  assign m_axis.tlast  = fifo_valid && fifo_dout[DATA_WIDTH];

endmodule

// File: tb/tb_pp_buf_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_pp_buf_rd_stream
// Drives pp_buf_rd_stream against a behavioural RAM and a frame-level model:
// banks are filled with random words, the model predicts the full flags, the
// sticky error, the word order of every frame and the release pulses.
// ---------------------------------------------------------------------------
module tb_pp_buf_rd_stream;

  logic        clk;
  logic        resetn;
  logic        wr_done_i;
  logic        wr_bank_i;
  logic        rd_release_o;
  logic        rd_rel_bank_o;
  logic [1:0]  bank_full_o;
  logic        ram_enb_o;
  logic [4:0]  ram_addrb_o;
  logic [31:0] ram_dob_i;
  logic        err_o;

  pp_buf_rd_stream_if #(.DATA_WIDTH(32)) axis ();

  pp_buf_rd_stream #(
    .DATA_WIDTH (32),
    .DEPTH      (16),
    .ADDRW      (4)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .wr_done_i     (wr_done_i),
    .wr_bank_i     (wr_bank_i),
    .rd_release_o  (rd_release_o),
    .rd_rel_bank_o (rd_rel_bank_o),
    .bank_full_o   (bank_full_o),
    .ram_enb_o     (ram_enb_o),
    .ram_addrb_o   (ram_addrb_o),
    .ram_dob_i     (ram_dob_i),
    .m_axis        (axis),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dp_ram port B: registered read, zero when not enabled.
  logic [31:0] ram_model [32];
  always @(posedge clk) ram_dob_i <= ram_enb_o ? ram_model[ram_addrb_o] : 32'd0;

  int n_asserts = 0;
  int n_fail    = 0;

  // Model state
  logic [1:0]  model_full;
  logic        model_err;
  int          model_bank;
  int          beat_idx;
  int          rd_idx;
  logic        rel_pending;
  int          rel_bank_exp;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;
  int          n_issued;
  int          n_acc;
  int          n_rel;
  int          n_beats;
  logic        saw_valid;
  int          tready_mode;   // 0: always ready, 1: random

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_full  = 2'b00;
    model_err   = 1'b0;
    model_bank  = 0;
    beat_idx    = 0;
    rd_idx      = 0;
    rel_pending = 1'b0;
    rel_bank_exp = 0;
    prev_stall  = 1'b0;
    prev_data   = 32'd0;
    prev_last   = 1'b0;
    n_issued    = 0;
    n_acc       = 0;
  endtask

  task automatic fill_bank(input int b);
    for (int i = 0; i < 16; i++) ram_model[b*16 + i] = $urandom;
  endtask

  // Called at the falling edge: compares this cycle's outputs with the model,
  // then advances the model by the events that the next rising edge commits.
  task automatic check_cycle();
    logic new_rel;
    new_rel = 1'b0;
    chk("bank_full", 64'(bank_full_o), 64'(model_full));
    chk("err", 64'(err_o), 64'(model_err));
    chk("release", 64'(rd_release_o), 64'(rel_pending));
    if (rel_pending) begin
      chk("rel_bank", 64'(rd_rel_bank_o), 64'(rel_bank_exp));
      n_rel++;
      $display("release bank=%0d", rd_rel_bank_o);
    end
    if (prev_stall) begin
      chk("stall_valid", 64'(axis.tvalid), 64'(1));
      chk("stall_data", 64'(axis.tdata), 64'(prev_data));
      chk("stall_last", 64'(axis.tlast), 64'(prev_last));
    end
    if (ram_enb_o) begin
      chk("read_only_full_bank", 64'(ram_enb_o), 64'(model_full[model_bank]));
      chk("read_addr", 64'(ram_addrb_o), 64'(model_bank*16 + rd_idx));
      rd_idx++;
      n_issued++;
    end
    if (axis.tvalid) saw_valid = 1'b1;
    if (axis.tvalid && axis.tready) begin
      chk("beat_data", 64'(axis.tdata), 64'(ram_model[(model_bank*16 + beat_idx) % 32]));
      chk("beat_last", 64'(axis.tlast), 64'(beat_idx == 15));
      $display("beat bank=%0d idx=%0d data=%08h last=%0b", model_bank, beat_idx, axis.tdata, axis.tlast);
      n_acc++;
      n_beats++;
      if (beat_idx == 15) begin
        model_full[model_bank] = 1'b0;
        new_rel      = 1'b1;
        rel_bank_exp = model_bank;
        model_bank   = model_bank ^ 1;
        beat_idx     = 0;
        rd_idx       = 0;
      end else begin
        beat_idx++;
      end
    end
    if (ram_enb_o) chk("outstanding_le2", 64'((n_issued - n_acc) <= 2), 64'(1));
    prev_stall = axis.tvalid && !axis.tready;
    prev_data  = axis.tdata;
    prev_last  = axis.tlast;
    if (wr_done_i) begin
      if (model_full[wr_bank_i]) model_err = 1'b1;
      model_full[wr_bank_i] = 1'b1;
    end
    rel_pending = new_rel;
  endtask

  // One clock period: drive inputs just after the rising edge, check at the fall.
  task automatic cyc(input logic done, input logic bank);
    wr_done_i   = done;
    wr_bank_i   = bank;
    axis.tready = (tready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    wr_done_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, 64'(axis.tvalid), 64'(0));
    chk({tag, "_release"}, 64'(rd_release_o), 64'(0));
    chk({tag, "_enb"}, 64'(ram_enb_o), 64'(0));
    chk({tag, "_full"}, 64'(bank_full_o), 64'(0));
    chk({tag, "_err"}, 64'(err_o), 64'(0));
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    #1;
    check_reset_outputs("reset");
    model_reset();
    repeat (2) cyc(1'b0, 1'b0);
    resetn = 1'b1;
    n_rel   = 0;
    n_beats = 0;
  endtask

  task automatic run_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((model_full != 2'b00 || rel_pending) && n < budget) begin
      cyc(1'b0, 1'b0);
      n++;
    end
    chk({tag, "_done_in_budget"}, 64'(n < budget), 64'(1));
  endtask

  initial begin
    int lat;
    int n;
    resetn      = 1'b0;
    wr_done_i   = 1'b0;
    wr_bank_i   = 1'b0;
    axis.tready = 1'b1;
    tready_mode = 0;
    n_rel       = 0;
    n_beats     = 0;
    saw_valid   = 1'b0;
    for (int i = 0; i < 32; i++) ram_model[i] = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // 1: single bank 0 frame, sink always ready, plus wr_done -> tvalid latency.
    apply_reset();
    fill_bank(0);
    cyc(1'b1, 1'b0);
    saw_valid = 1'b0;
    lat = 0;
    while (!saw_valid && lat < 10) begin
      cyc(1'b0, 1'b0);
      lat++;
    end
    // wr_done_i sampled on one edge; tvalid rises after the third edge following it.
    chk("t1_latency", 64'(lat), 64'(4));
    run_idle(60, "t1");
    chk("t1_beats", 64'(n_beats), 64'(16));
    chk("t1_releases", 64'(n_rel), 64'(1));

    // 2: both banks back to back.
    apply_reset();
    fill_bank(0);
    fill_bank(1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    run_idle(100, "t2");
    chk("t2_beats", 64'(n_beats), 64'(32));
    chk("t2_releases", 64'(n_rel), 64'(2));

    // 3: random back-pressure over two frames.
    apply_reset();
    tready_mode = 1;
    fill_bank(0);
    fill_bank(1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    run_idle(400, "t3");
    chk("t3_beats", 64'(n_beats), 64'(32));
    chk("t3_releases", 64'(n_rel), 64'(2));
    tready_mode = 0;

    // 4: bank 1 first must wait for bank 0.
    apply_reset();
    fill_bank(1);
    cyc(1'b1, 1'b1);
    repeat (30) cyc(1'b0, 1'b0);
    chk("t4_no_stream", 64'(n_beats), 64'(0));
    chk("t4_full_b1", 64'(bank_full_o), 64'(2'b10));
    fill_bank(0);
    cyc(1'b1, 1'b0);
    run_idle(100, "t4");
    chk("t4_beats", 64'(n_beats), 64'(32));
    chk("t4_releases", 64'(n_rel), 64'(2));

    // 5: double wr_done on a full bank.
    apply_reset();
    fill_bank(0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    run_idle(60, "t5");
    repeat (3) cyc(1'b0, 1'b0);
    chk("t5_err_sticky", 64'(err_o), 64'(1));
    chk("t5_beats", 64'(n_beats), 64'(16));
    chk("t5_releases", 64'(n_rel), 64'(1));

    // 6: reset in the middle of a frame, then a clean frame.
    apply_reset();
    fill_bank(0);
    cyc(1'b1, 1'b0);
    n = 0;
    while (beat_idx != 7 && n < 40) begin
      cyc(1'b0, 1'b0);
      n++;
    end
    chk("t6_reached_beat7", 64'(beat_idx), 64'(7));
    resetn = 1'b0;
    #1;
    check_reset_outputs("t6_midframe");
    model_reset();
    repeat (3) cyc(1'b0, 1'b0);
    resetn  = 1'b1;
    n_rel   = 0;
    n_beats = 0;
    repeat (3) cyc(1'b0, 1'b0);
    chk("t6_no_release", 64'(n_rel), 64'(0));
    fill_bank(0);
    cyc(1'b1, 1'b0);
    run_idle(60, "t6");
    chk("t6_beats", 64'(n_beats), 64'(16));
    chk("t6_releases", 64'(n_rel), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
